// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
// Optional subtraction support is enabled with the BCD_SUB_EN macro.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

    // Invalid digits wrap here; they are flagged separately through err.
    function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Purely combinational single-digit BCD adder shared by the serial controller.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t x,
    input  bcd_digit_t y,
    input  logic       c,
    output bcd_digit_t d_sum,
    output logic       d_cout
);

    logic [4:0] t;

    // Binary sum followed by decimal correction when it leaves the 0..9 range.
    always_comb begin
        t      = {1'b0, x} + {1'b0, y} + {4'd0, c};
        d_sum  = t[3:0];
        d_cout = 1'b0;
        if (t > {1'b0, BCD_MAX}) begin
            d_sum  = t[3:0] + BCD_CORR;
            d_cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder controller: one digit per clock, LSD first.
// Define BCD_SUB_EN to add the sub port for ten's-complement subtraction.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
`ifdef BCD_SUB_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] s,
    output logic                cout,
    output logic                err
);

    localparam int W    = 4 * DIGITS;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    s_q, s_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;
`ifdef BCD_SUB_EN
    logic            sub_q, sub_d;
`endif

    bcd_digit_t curA, curB, effB, dSum;
    logic       dCout, digitErr;

    // Select the operand digits addressed by the current index.
    always_comb begin
        curA = '0;
        curB = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                curA = a_q[4*i +: 4];
                curB = b_q[4*i +: 4];
            end
        end
`ifdef BCD_SUB_EN
        effB = sub_q ? nines_comp(curB) : curB;
`else
        effB = curB;
`endif
        digitErr = (curA > BCD_MAX) | (curB > BCD_MAX);
    end

    bcd_digit_add u_digit_add (
        .x      (curA),
        .y      (effB),
        .c      (carry_q),
        .d_sum  (dSum),
        .d_cout (dCout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        err_d   = err_q;
`ifdef BCD_SUB_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    s_d     = '0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef BCD_SUB_EN
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : cin;
`else
                    carry_d = cin;
`endif
                end
            end
            RUN: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        s_d[4*i +: 4] = dSum;
                    end
                end
                carry_d = dCout;
                err_d   = err_q | digitErr;
                if (idx_q == LAST_IDX) begin
                    cout_d  = dCout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef BCD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
`ifdef BCD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (DIGITS=3): table vectors,
// hand-written corner sequences and randomized operations against a decimal model.
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 3;
    localparam int W      = 4 * DIGITS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef BCD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         err;

    int checksTotal  = 0;
    int checksPassed = 0;

    int           gotLat;
    int           gotBusy;
    logic [W-1:0] gotS;
    logic         gotCout;
    logic         gotErr;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic [W-1:0] expS;
        logic         expCout;
        logic         expErr;
        logic         careSum;
    } vec_t;

    vec_t vecs[6];

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef BCD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checksTotal++;
        if (act === exp) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int bcdToInt(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] intToBcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic hasBadDigit(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // Start one operation and wait (bounded) for done; captures latency and result.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tc, input logic tsub);
        @(negedge clk);
        a = ta;
        b = tb;
        cin = tc;
`ifdef BCD_SUB_EN
        sub = tsub;
`endif
        start = 1'b1;
        gotLat = -1;
        gotBusy = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            a = '0;
            b = '0;
            if (busy) gotBusy++;
            if (done) begin
                gotLat = n;
                gotS = s;
                gotCout = cout;
                gotErr = err;
                break;
            end
        end
        if (tsub) gotBusy = gotBusy;
    endtask

    initial begin
        int doneCount;
        int powD;
        logic [W-1:0] ra, rb;
        logic rc;
        int refSum;

        vecs[0] = '{12'h002, 12'h003, 1'b0, 12'h005, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{12'h222, 12'h333, 1'b0, 12'h555, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{12'h888, 12'h333, 1'b0, 12'h221, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{12'h999, 12'h000, 1'b1, 12'h000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{12'h0A1, 12'h001, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0, 1'b1};

        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef BCD_SUB_EN
        sub = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_s", {20'd0, s}, 32'd0);
        checkOutput("reset_cout", {31'd0, cout}, 32'd0);
        checkOutput("reset_err", {31'd0, err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].va, vecs[v].vb, vecs[v].vcin, 1'b0);
            checkOutput($sformatf("vec%0d_latency", v), 32'(gotLat), 32'(DIGITS + 1));
            checkOutput($sformatf("vec%0d_busycycles", v), 32'(gotBusy), 32'(DIGITS));
            checkOutput($sformatf("vec%0d_err", v), {31'd0, gotErr}, {31'd0, vecs[v].expErr});
            if (vecs[v].careSum) begin
                checkOutput($sformatf("vec%0d_s", v), {20'd0, gotS}, {20'd0, vecs[v].expS});
                checkOutput($sformatf("vec%0d_cout", v), {31'd0, gotCout}, {31'd0, vecs[v].expCout});
            end
            @(negedge clk);
            checkOutput($sformatf("vec%0d_done_pulse", v), {31'd0, done}, 32'd0);
            checkOutput($sformatf("vec%0d_s_hold", v), {20'd0, s}, {20'd0, gotS});
        end

`ifdef BCD_SUB_EN
        applyStimulus(12'h500, 12'h123, 1'b0, 1'b1);
        checkOutput("sub_pos_s", {20'd0, gotS}, 32'h377);
        checkOutput("sub_pos_cout", {31'd0, gotCout}, 32'd1);
        applyStimulus(12'h123, 12'h500, 1'b1, 1'b1);
        checkOutput("sub_neg_s", {20'd0, gotS}, 32'h623);
        checkOutput("sub_neg_cout", {31'd0, gotCout}, 32'd0);
`endif

        // Start re-asserted during RUN must be ignored
        @(negedge clk);
        a = 12'h111;
        b = 12'h222;
        cin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 12'h777;
        b = 12'h777;
        start = 1'b1;
        doneCount = 0;
        gotS = '0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                doneCount++;
                gotS = s;
            end
        end
        checkOutput("ignore_start_s", {20'd0, gotS}, 32'h333);
        checkOutput("ignore_start_donecount", 32'(doneCount), 32'd1);

        // Asynchronous reset in the middle of RUN
        applyStimulus(12'h999, 12'h001, 1'b0, 1'b0);
        @(negedge clk);
        a = 12'h555;
        b = 12'h111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrun_reset_s", {20'd0, s}, 32'd0);
        checkOutput("midrun_reset_cout", {31'd0, cout}, 32'd0);
        checkOutput("midrun_reset_err", {31'd0, err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        doneCount = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("midrun_reset_nodone", 32'(doneCount), 32'd0);

        // Randomized operations against a decimal reference model
        powD = 1;
        for (int i = 0; i < DIGITS; i++) powD = powD * 10;
        for (int r = 0; r < 40; r++) begin
            ra = '0;
            rb = '0;
            for (int i = 0; i < DIGITS; i++) begin
                ra[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                rb[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            rc = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rc, 1'b0);
            checkOutput($sformatf("rand%0d_latency", r), 32'(gotLat), 32'(DIGITS + 1));
            checkOutput($sformatf("rand%0d_err", r), {31'd0, gotErr},
                        {31'd0, hasBadDigit(ra) | hasBadDigit(rb)});
            if (!hasBadDigit(ra) && !hasBadDigit(rb)) begin
                refSum = bcdToInt(ra) + bcdToInt(rb) + int'(rc);
                checkOutput($sformatf("rand%0d_s", r), {20'd0, gotS}, {20'd0, intToBcd(refSum % powD)});
                checkOutput($sformatf("rand%0d_cout", r), {31'd0, gotCout}, {31'd0, refSum >= powD});
            end
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
Digit-serial controller for multi-digit BCD addition. It latches two packed BCD operands on a start handshake, then steps one shared single-digit BCD adder across the digits, one digit per clock, LSD first, rippling the carry. It presents the packed sum, carry-out and an invalid-digit flag with a one-cycle done pulse. It replaces a wide combinational digit-adder chain where area matters more than latency.

Parameters:
DIGITS, 3, number of BCD digits per operand (valid range 1..8)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only in IDLE
a  input  4*DIGITS  packed BCD operand; digit i occupies bits [4i+3:4i]
b  input  4*DIGITS  packed BCD operand, same packing as a
cin  input  1  carry into digit 0
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse when the result becomes valid
s  output  4*DIGITS  packed BCD sum; held until the next accepted start
cout  output  1  carry out of the most significant digit
err  output  1  high if any operand digit exceeds 9 (sticky per operation)

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, busy=0, done=0, s=0, cout=0, err=0, digit index=0, carry reg=0, operand regs=0.
- State IDLE:
  - start=1 latches a, b and cin; clears s, err and index; moves to RUN.
  - start=0: stays in IDLE; outputs hold.
- State RUN (busy=1), one digit per cycle at index k:
  - Digit adder input: a_reg[k], b_reg[k], carry.
  - Output s[k] = d_sum; carry <= d_cout.
  - err <= err | (a_reg[k]>9) | (b_reg[k]>9).
  - k = DIGITS-1: cout <= d_cout; move to DONE. Otherwise k <= k+1.
- State DONE: done=1 for exactly one cycle, busy=0; moves to IDLE unconditionally.
- Latency: start sampled at edge T gives done high in cycle T+DIGITS+1. Throughput is one operation per DIGITS+2 cycles.
- Digit arithmetic: 5-bit t = x + y + c. If t > 9, d_sum = (t+6) mod 16 and d_cout=1; otherwise d_sum = t[3:0] and d_cout=0. Invalid digits (>9) are still processed by this rule; err flags them and the result is don't-care.
- start while in RUN or DONE is ignored. It is not queued. Operands may change freely after acceptance.
- s digits above the current index read 0 during RUN. s is architecturally valid only from the done cycle until the next accepted start.
- Reset asserted mid-operation aborts immediately to reset values. No done pulse is produced.
- DIGITS=1: RUN lasts one cycle.

Optional Feature:
BCD_SUB_EN:
- Defined: adds input port sub (1 bit), latched with the operands on start.
  - sub=1: each b digit is replaced by its nine's complement (9-b) before the digit adder, and the carry reg is loaded with 1 (the cin port is ignored). The result is a - b in ten's complement.
  - cout=1 means no borrow (a >= b); cout=0 means the result is the ten's complement of a negative difference.
  - err is evaluated on the original b digits.
- Undefined: no sub port; addition only.

Decomposition:
- Package bcd_pkg:
  - typedef bcd_digit_t (4 bits).
  - FSM state enum {IDLE, RUN, DONE}.
  - Constants BCD_MAX=9 and BCD_CORR=6.
  - Function nines_comp.
- One natural sub-module: bcd_digit_add, a purely combinational single-digit adder with inputs x, y, c and outputs d_sum, d_cout. The controller instantiates it once.

Test Plan (DIGITS=3):
- a=0x002, b=0x003, cin=0, start pulse -> done 4 cycles later; s=0x005, cout=0, err=0; busy high for exactly 3 cycles.
- a=0x222, b=0x333 -> s=0x555, cout=0. Then a=0x888, b=0x333 -> s=0x221, cout=1.
- a=0x999, b=0x000, cin=1 -> s=0x000, cout=1 (full carry ripple).
- a=0x0A1, b=0x001 -> err=1 at done. A following valid operation clears err to 0.
- start re-asserted during RUN with different operands -> ignored; original result and a single done pulse. rst_n pulsed low mid-RUN -> all outputs 0 asynchronously; no done pulse.
- BCD_SUB_EN: a=0x500, b=0x123, sub=1 -> s=0x377, cout=1. a=0x123, b=0x500, sub=1 -> s=0x623, cout=0.
